// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC, old-PC and instruction registers and fetches
// one instruction per request over a valid/ready request, valid-only response bus.
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_fetch_req,
    input  logic                  i_pc_update,
    input  logic [ADDR_WIDTH-1:0] i_pc_next,
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic                  i_mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    input  logic                  i_mem_err,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [ADDR_WIDTH-1:0] o_old_pc,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic [6:0]            o_op,
    output logic [2:0]            o_func_3,
    output logic                  o_func_7_5,
    output logic                  o_fetch_done,
    output logic                  o_fetch_err,
    output logic                  o_busy
);

    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]   old_pc_q, old_pc_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    mis_err_q, mis_err_d;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        old_pc_d  = old_pc_q;
        instr_d   = instr_q;
        addr_d    = addr_q;
        mis_err_d = 1'b0;

        // PC writes are independent of the fetch sequence; the in-flight address lives in addr_q.
        if (i_pc_update) begin
            pc_d = i_pc_next;
        end

        case (state_q)
            S_IDLE: begin
                if (i_fetch_req) begin
                    if (pc_q[1:0] == 2'b00) begin
                        addr_d  = pc_q;
                        state_d = S_REQ;
                    end else begin
                        mis_err_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (i_mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_mem_resp_valid) begin
                    if (i_mem_err) begin
                        state_d = S_ERR;
                    end else begin
                        instr_d  = i_mem_rdata;
                        old_pc_d = addr_q;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            old_pc_q  <= RESET_PC;
            instr_q   <= NOP_INSTR;
            addr_q    <= '0;
            mis_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            old_pc_q  <= old_pc_d;
            instr_q   <= instr_d;
            addr_q    <= addr_d;
            mis_err_q <= mis_err_d;
        end
    end

    assign o_mem_req_valid = (state_q == S_REQ);
    assign o_mem_addr      = addr_q;
    assign o_pc            = pc_q;
    assign o_old_pc        = old_pc_q;
    assign o_instr         = instr_q;
    assign o_op            = instr_q[6:0];
    assign o_func_3        = instr_q[14:12];
    assign o_func_7_5      = instr_q[30];
    assign o_fetch_done    = (state_q == S_DONE);
    // Misalignment is flagged from IDLE, so it does not raise o_busy.
    assign o_fetch_err     = (state_q == S_ERR) | mis_err_q;
    assign o_busy          = (state_q != S_IDLE);

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream stage of the multicycle core's main control FSM.
- Owns the PC, old-PC and instruction registers.
- Fetches instructions from a variable-latency instruction memory over a valid/ready request and valid-only response interface.
- Presents decoded opcode, func3 and func7[5] fields to the control FSM, plus a done strobe so the FSM can stall in FETCH until the instruction is valid.

Parameters:
- ADDR_WIDTH, 32, PC and memory address width.
- DATA_WIDTH, 32, instruction width (fixed 32 for RV32).
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- i_fetch_req  input  1  start fetch at current PC (FSM in FETCH).
- i_pc_update  input  1  load PC from i_pc_next.
- i_pc_next  input  ADDR_WIDTH  next PC from the result mux.
- o_mem_req_valid  output  1  memory request valid.
- i_mem_req_ready  input  1  memory accepts request.
- o_mem_addr  output  ADDR_WIDTH  request address; held stable while valid.
- i_mem_resp_valid  input  1  read data valid.
- i_mem_rdata  input  DATA_WIDTH  read data.
- i_mem_err  input  1  bus error, qualified by i_mem_resp_valid.
- o_pc  output  ADDR_WIDTH  current PC register.
- o_old_pc  output  ADDR_WIDTH  address of the instruction in o_instr.
- o_instr  output  DATA_WIDTH  instruction register.
- o_op  output  7  o_instr[6:0].
- o_func_3  output  3  o_instr[14:12].
- o_func_7_5  output  1  o_instr[30].
- o_fetch_done  output  1  one-cycle pulse: new o_instr valid.
- o_fetch_err  output  1  one-cycle pulse: misaligned PC or bus error.
- o_busy  output  1  fetch in progress (state != IDLE).

Behaviour:
Reset and clocking:
- Clock is clk; reset is rst, synchronous and active-high.
- Reset values: state IDLE, o_pc = RESET_PC, o_old_pc = RESET_PC, o_instr = 32'h0000_0013 (addi x0,x0,0). o_mem_req_valid, o_fetch_done, o_fetch_err and o_busy are 0; o_mem_addr = 0.
- Reset mid-operation abandons the fetch. Responses arriving after reset are ignored, because IDLE ignores i_mem_resp_valid.

States:
- IDLE:
  - i_fetch_req with o_pc[1:0]==0: latch fetch address A = o_pc, go to REQ.
  - i_fetch_req with o_pc[1:0]!=0: o_fetch_err=1 next cycle (registered pulse), stay IDLE, no memory request.
  - Otherwise stay in IDLE.
- REQ:
  - o_mem_req_valid=1, o_mem_addr=A.
  - On i_mem_req_ready go to WAIT; otherwise hold valid and address unchanged.
- WAIT:
  - On i_mem_resp_valid & !i_mem_err: o_instr <= i_mem_rdata, o_old_pc <= A, go to DONE.
  - On i_mem_resp_valid & i_mem_err: o_instr and o_old_pc unchanged, go to ERR.
  - A response is never accepted in the same cycle as request acceptance.
- DONE: o_fetch_done=1 for exactly one cycle, then IDLE.
- ERR: o_fetch_err=1 for exactly one cycle, then IDLE.

Other rules:
- o_busy = 1 in REQ, WAIT, DONE and ERR.
- i_fetch_req while not IDLE is ignored; it is not queued.
- i_pc_update loads o_pc <= i_pc_next in any state, including during reset-free REQ/WAIT. The in-flight address A is unaffected. If rst and i_pc_update are both asserted, rst wins.
- No PC increment in this block; PC+4 comes from the datapath via i_pc_next.
- o_op, o_func_3 and o_func_7_5 are combinational slices of o_instr, so they change the cycle o_fetch_done rises.
- Minimum latency: i_fetch_req at cycle 0, valid at cycle 1 (ready=1), response at cycle 2, o_fetch_done at cycle 3.

Test Plan:
- Reset, then release: o_pc=0, o_instr=0x00000013, o_op=7'b0010011, all strobes 0, o_busy=0.
- PC=0x100, i_fetch_req pulse, ready=1, response 0x00A00093 one cycle after acceptance:
  - o_mem_addr=0x100 at cycle 1.
  - o_fetch_done at cycle 3 with o_instr=0x00A00093, o_old_pc=0x100, o_op=0x13, o_func_3=0.
- Backpressure: ready low 3 cycles, response 4 cycles later:
  - valid and o_mem_addr held constant throughout.
  - exactly one o_fetch_done; a second i_fetch_req during WAIT is ignored (one request total).
- i_pc_update with i_pc_next=0x204 during WAIT:
  - o_pc=0x204 immediately after.
  - the completed fetch reports o_old_pc=0x100; the next fetch requests 0x204.
- PC=0x102 with i_fetch_req: o_fetch_err pulse next cycle, o_mem_req_valid never asserts, o_instr unchanged.
- Errors and reset:
  - Bus error response: o_fetch_err 1 cycle, no o_fetch_done, o_instr retains its previous value.
  - rst asserted in WAIT, then a late i_mem_resp_valid: state IDLE, o_instr=0x00000013, no strobes.
